// File: rtl/riscv_pkg.sv
// RV32I decode constants shared by the ID stage: opcodes, result-select and ALU encodings.
// Constants and types only, so there is no latency or flow control here.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic [1:0] result_src;
    logic [3:0] alu_control;
  } ctrl_t;

endpackage

// File: rtl/control.sv
// RV32I main decoder: opcode/funct fields to control bundle; known=0 flags an undefined opcode.
// Purely combinational, no flow control.
module control
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output ctrl_t      ctrl,
  output logic       known
);

  logic [3:0] alu_arith;

  always_comb begin
    case (funct3)
      3'b000:  alu_arith = (opcode == OP_REG && funct7_b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_arith = ALU_SLL;
      3'b010:  alu_arith = ALU_SLT;
      3'b011:  alu_arith = ALU_SLTU;
      3'b100:  alu_arith = ALU_XOR;
      3'b101:  alu_arith = funct7_b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_arith = ALU_OR;
      default: alu_arith = ALU_AND;
    endcase
  end

  always_comb begin
    ctrl  = '0;
    known = 1'b1;
    case (opcode)
      OP_REG:    begin ctrl.regwrite = 1'b1; ctrl.alu_control = alu_arith; end
      OP_IMM:    begin ctrl.regwrite = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_control = alu_arith; end
      OP_LOAD:   begin ctrl.regwrite = 1'b1; ctrl.alu_src = 1'b1; ctrl.result_src = RES_MEM; end
      OP_STORE:  begin ctrl.memwrite = 1'b1; ctrl.alu_src = 1'b1; end
      OP_BRANCH: begin ctrl.branch = 1'b1; ctrl.alu_control = ALU_SUB; end
      OP_JAL:    begin ctrl.regwrite = 1'b1; ctrl.jump = 1'b1; ctrl.result_src = RES_PC4; end
      OP_JALR:   begin ctrl.regwrite = 1'b1; ctrl.jump = 1'b1; ctrl.alu_src = 1'b1; ctrl.result_src = RES_PC4; end
      OP_LUI:    begin ctrl.regwrite = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_control = ALU_PASSB; end
      OP_AUIPC:  begin ctrl.regwrite = 1'b1; ctrl.alu_src = 1'b1; end
      default:   known = 1'b0;
    endcase
  end

endmodule

// File: rtl/imm_gen.sv
// RV32I immediate extraction and sign extension by instruction format; R-type and unknown give 0.
// Purely combinational, no flow control.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] instruction,
  output logic [31:0] imm
);

  always_comb begin
    case (instruction[6:0])
      OP_LOAD, OP_IMM, OP_JALR: imm = {{20{instruction[31]}}, instruction[31:20]};
      OP_STORE:  imm = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      OP_BRANCH: imm = {{19{instruction[31]}}, instruction[31], instruction[7],
                        instruction[30:25], instruction[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm = {instruction[31:12], 12'b0};
      OP_JAL:    imm = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                        instruction[20], instruction[30:21], 1'b0};
      default:   imm = '0;
    endcase
  end

endmodule

// File: rtl/regfile.sv
// 2-read/1-write register file, x0 hardwired to zero, optional write-to-read bypass.
// Reads combinational, writes land on the next clk edge; no flow control.
module regfile #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int RW     = $clog2(NREGS),
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [RW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [RW-1:0]   raddr1,
  input  logic [RW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (we && waddr != '0) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) regs_q <= '{default: '0};
    else       regs_q <= regs_d;
  end

  // Zero check comes last so a bypassed write to x0 can never leak through.
  always_comb begin
    rdata1 = regs_q[raddr1];
    rdata2 = regs_q[raddr2];
    if (BYPASS != 0 && we && waddr == raddr1) rdata1 = wdata;
    if (BYPASS != 0 && we && waddr == raddr2) rdata2 = wdata;
    if (raddr1 == '0) rdata1 = '0;
    if (raddr2 == '0) rdata2 = '0;
  end

endmodule

// File: rtl/id_stage_pipe.sv
// RV32I decode stage plus ID/EX register: 1-cycle latency from ID inputs to ID/EX outputs.
// stall holds ID/EX, flush or a load-use hazard inserts a bubble; load_use_stall holds PC and IF/ID.
module id_stage_pipe
  import riscv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int RW     = $clog2(NREGS),
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pc_plus_4,
  input  logic            stall,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [RW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            load_use_stall,
  output logic            id_valid,
  output logic [XLEN-1:0] immediate,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [RW-1:0]   rs1_out,
  output logic [RW-1:0]   rs2_out,
  output logic [RW-1:0]   rd_out,
  output logic            regwrite_d,
  output logic            memwrite_d,
  output logic            jump_d,
  output logic            branch_d,
  output logic            alu_src_d,
  output logic [1:0]      result_src_d,
  output logic [3:0]      alu_control_d,
  output logic [XLEN-1:0] id_ex_pc,
  output logic [XLEN-1:0] id_ex_pc_plus_4
);

  typedef struct packed {
    logic            valid;
    ctrl_t           ctrl;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } idex_t;

  idex_t           idex_q, idex_d, fetched;
  ctrl_t           dec_ctrl;
  logic            dec_known;
  logic [31:0]     imm32;
  logic [RW-1:0]   rs1_idx, rs2_idx, rd_idx;
  logic [XLEN-1:0] rf_rd1, rf_rd2;

  assign rs1_idx = RW'(instruction[19:15]);
  assign rs2_idx = RW'(instruction[24:20]);
  assign rd_idx  = RW'(instruction[11:7]);

  control u_control (
    .opcode    (instruction[6:0]),
    .funct3    (instruction[14:12]),
    .funct7_b5 (instruction[30]),
    .ctrl      (dec_ctrl),
    .known     (dec_known)
  );

  imm_gen u_imm_gen (
    .instruction (instruction),
    .imm         (imm32)
  );

  regfile #(.XLEN(XLEN), .NREGS(NREGS), .RW(RW), .BYPASS(BYPASS)) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .we     (wb_en),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (rs1_idx),
    .raddr2 (rs2_idx),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2)
  );

  // The load in EX cannot forward in time, so the dependent instruction waits one cycle.
  assign load_use_stall = idex_q.valid && idex_q.ctrl.regwrite &&
                          idex_q.ctrl.result_src == RES_MEM && idex_q.rd != '0 && if_valid &&
                          (idex_q.rd == rs1_idx || idex_q.rd == rs2_idx);

  always_comb begin
    fetched       = '0;
    fetched.valid = 1'b1;
    if (dec_known) begin
      fetched.ctrl     = dec_ctrl;
      fetched.imm      = XLEN'($signed(imm32));
      fetched.rs1_data = rf_rd1;
      fetched.rs2_data = rf_rd2;
      fetched.rs1      = rs1_idx;
      fetched.rs2      = rs2_idx;
      fetched.rd       = rd_idx;
      fetched.pc       = pc;
      fetched.pc4      = pc_plus_4;
    end

    idex_d = idex_q;
    if (flush)                                idex_d = '0;
    else if (!stall && (load_use_stall || !if_valid)) idex_d = '0;
    else if (!stall)                          idex_d = fetched;
  end

  always_ff @(posedge clk) begin
    if (reset) idex_q <= '0;
    else       idex_q <= idex_d;
  end

  assign id_valid        = idex_q.valid;
  assign regwrite_d      = idex_q.ctrl.regwrite;
  assign memwrite_d      = idex_q.ctrl.memwrite;
  assign jump_d          = idex_q.ctrl.jump;
  assign branch_d        = idex_q.ctrl.branch;
  assign alu_src_d       = idex_q.ctrl.alu_src;
  assign result_src_d    = idex_q.ctrl.result_src;
  assign alu_control_d   = idex_q.ctrl.alu_control;
  assign immediate       = idex_q.imm;
  assign rs1_data        = idex_q.rs1_data;
  assign rs2_data        = idex_q.rs2_data;
  assign rs1_out         = idex_q.rs1;
  assign rs2_out         = idex_q.rs2;
  assign rd_out          = idex_q.rd;
  assign id_ex_pc        = idex_q.pc;
  assign id_ex_pc_plus_4 = idex_q.pc4;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: per-cycle compare against a behavioural model plus literal pins.
// A second instance with BYPASS=0 is used only for the same-cycle writeback read case.
module tb_id_stage_pipe;
  import riscv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, if_valid, stall, flush, wb_en;
  logic [31:0] instruction, pc, pc_plus_4, wb_data;
  logic [4:0]  wb_rd;

  logic        load_use_stall, id_valid, regwrite_d, memwrite_d, jump_d, branch_d, alu_src_d;
  logic [31:0] immediate, rs1_data, rs2_data, id_ex_pc, id_ex_pc_plus_4;
  logic [4:0]  rs1_out, rs2_out, rd_out;
  logic [1:0]  result_src_d;
  logic [3:0]  alu_control_d;

  logic        nb_lus, nb_valid, nb_rw, nb_mw, nb_j, nb_b, nb_src;
  logic [31:0] nb_imm, nb_rs1_data, nb_rs2_data, nb_pc, nb_pc4;
  logic [4:0]  nb_rs1, nb_rs2, nb_rd;
  logic [1:0]  nb_res;
  logic [3:0]  nb_alu;

  id_stage_pipe dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .instruction(instruction), .pc(pc),
    .pc_plus_4(pc_plus_4), .stall(stall), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .load_use_stall(load_use_stall), .id_valid(id_valid),
    .immediate(immediate), .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_out(rs1_out),
    .rs2_out(rs2_out), .rd_out(rd_out), .regwrite_d(regwrite_d), .memwrite_d(memwrite_d),
    .jump_d(jump_d), .branch_d(branch_d), .alu_src_d(alu_src_d), .result_src_d(result_src_d),
    .alu_control_d(alu_control_d), .id_ex_pc(id_ex_pc), .id_ex_pc_plus_4(id_ex_pc_plus_4)
  );

  id_stage_pipe #(.BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .if_valid(if_valid), .instruction(instruction), .pc(pc),
    .pc_plus_4(pc_plus_4), .stall(stall), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .load_use_stall(nb_lus), .id_valid(nb_valid),
    .immediate(nb_imm), .rs1_data(nb_rs1_data), .rs2_data(nb_rs2_data), .rs1_out(nb_rs1),
    .rs2_out(nb_rs2), .rd_out(nb_rd), .regwrite_d(nb_rw), .memwrite_d(nb_mw),
    .jump_d(nb_j), .branch_d(nb_b), .alu_src_d(nb_src), .result_src_d(nb_res),
    .alu_control_d(nb_alu), .id_ex_pc(nb_pc), .id_ex_pc_plus_4(nb_pc4)
  );

  typedef struct packed {
    logic        valid, regwrite, memwrite, jump, branch, alu_src;
    logic [1:0]  res;
    logic [3:0]  alu;
    logic [31:0] imm, rs1d, rs2d;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pc, pc4;
  } ent_t;

  ent_t dut_ent;
  assign dut_ent = {id_valid, regwrite_d, memwrite_d, jump_d, branch_d, alu_src_d, result_src_d,
                    alu_control_d, immediate, rs1_data, rs2_data, rs1_out, rs2_out, rd_out,
                    id_ex_pc, id_ex_pc_plus_4};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_ent(input string nm, input ent_t act, input ent_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam logic [3:0] F3_ALU [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                                        ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
  logic [31:0] m_rf [32];
  ent_t        m_q = '0;
  logic        m_ok = 1'b0;
  logic [31:0] cur_imm;   // immediate that the current vector was assembled with

  function automatic ent_t m_ctl(input logic [31:0] ins);
    ent_t e = '0;
    logic [3:0] ar;
    ar = F3_ALU[ins[14:12]];
    if (ins[14:12] == 3'b101 && ins[30]) ar = ALU_SRA;
    e.valid = 1'b1;
    case (ins[6:0])
      OP_REG:    begin e.regwrite = 1; e.alu = (ins[14:12] == 3'b000 && ins[30]) ? ALU_SUB : ar; end
      OP_IMM:    begin e.regwrite = 1; e.alu_src = 1; e.alu = ar; end
      OP_LOAD:   begin e.regwrite = 1; e.alu_src = 1; e.res = RES_MEM; end
      OP_STORE:  begin e.memwrite = 1; e.alu_src = 1; end
      OP_BRANCH: begin e.branch = 1; e.alu = ALU_SUB; end
      OP_JAL:    begin e.regwrite = 1; e.jump = 1; e.res = RES_PC4; end
      OP_JALR:   begin e.regwrite = 1; e.jump = 1; e.alu_src = 1; e.res = RES_PC4; end
      OP_LUI:    begin e.regwrite = 1; e.alu_src = 1; e.alu = ALU_PASSB; end
      OP_AUIPC:  begin e.regwrite = 1; e.alu_src = 1; end
      default:   e.valid = 1'b0;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
    if (wb_en && wb_rd == r) return wb_data;
    return m_rf[r];
  endfunction

  function automatic ent_t m_load();
    ent_t e;
    e = m_ctl(instruction);
    if (!e.valid) begin
      e = '0;
      e.valid = 1'b1;
      return e;
    end
    e.imm  = cur_imm;
    e.rs1  = instruction[19:15];
    e.rs2  = instruction[24:20];
    e.rd   = instruction[11:7];
    e.rs1d = m_read(e.rs1);
    e.rs2d = m_read(e.rs2);
    e.pc   = pc;
    e.pc4  = pc_plus_4;
    return e;
  endfunction

  function automatic logic m_lus();
    return m_q.valid && m_q.regwrite && m_q.res == RES_MEM && m_q.rd != 5'd0 && if_valid &&
           (m_q.rd == instruction[19:15] || m_q.rd == instruction[24:20]);
  endfunction

  initial begin : compare_proc
    ent_t nxt;
    logic exp_lus;
    forever begin
      @(negedge clk);
      #2;
      exp_lus = 1'b0;
      if (m_ok) begin
        exp_lus = m_lus();
        chk32("model load_use_stall", {31'b0, load_use_stall}, {31'b0, exp_lus});
      end
      if (reset || flush)            nxt = '0;
      else if (stall)                nxt = m_q;
      else if (exp_lus || !if_valid) nxt = '0;
      else                           nxt = m_load();
      @(posedge clk);
      #1;
      if (reset) begin
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        m_ok = 1'b1;
      end else if (wb_en && wb_rd != 5'd0) begin
        m_rf[wb_rd] = wb_data;
      end
      m_q = nxt;
      if (m_ok) chk_ent("model id/ex", dut_ent, m_q);
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [31:0] pc_ctr = 32'h1000;

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP_REG};
  endfunction
  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [4:0] rs2, rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
  endfunction
  function automatic logic [31:0] b_type(input logic [12:0] imm, input logic [4:0] rs2, rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OP_BRANCH};
  endfunction
  function automatic logic [31:0] j_type(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
  endfunction

  task automatic put(input logic [31:0] ins, input logic [31:0] imm, input logic v,
                     input logic st, input logic fl, input logic we, input logic [4:0] wr,
                     input logic [31:0] wd, input logic rst);
    instruction = ins; cur_imm = imm; if_valid = v; stall = st; flush = fl;
    wb_en = we; wb_rd = wr; wb_data = wd; reset = rst;
    pc = pc_ctr; pc_plus_4 = pc_ctr + 32'd4;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cyc(input logic [31:0] ins, input logic [31:0] imm);
    put(ins, imm, 1, 0, 0, 0, 0, 0, 0);
    tick();
    pc_ctr += 32'd4;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] d);
    put(32'h0, 0, 0, 0, 0, 1, rd, d, 0);
    tick();
  endtask

  logic [31:0] lw8, add9;
  ent_t        exp_e;

  initial begin : stim
    put(32'h0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    tick();
    chk32("reset id_valid", {31'b0, id_valid}, 32'h0);
    chk32("reset rs1_data", rs1_data, 32'h0);
    chk32("reset load_use_stall", {31'b0, load_use_stall}, 32'h0);

    wb(5'd1, 32'h100);
    wb(5'd2, 32'h7);
    wb(5'd5, 32'hDEADBEEF);
    wb(5'd7, 32'h55);

    // add x6,x5,x0 after x5 write
    cyc(r_type(7'h00, 5'd0, 5'd5, 3'b000, 5'd6), 0);
    chk32("add rs1_data", rs1_data, 32'hDEADBEEF);
    chk32("add rs2_data", rs2_data, 32'h0);
    chk32("add regwrite", {31'b0, regwrite_d}, 32'h1);
    chk32("add rd_out", {27'b0, rd_out}, 32'd6);

    // x0 write ignored, also for same-cycle bypass
    put(i_type(12'd5, 5'd0, 3'b000, 5'd10, OP_IMM), 32'd5, 1, 0, 0, 1, 5'd0, 32'hFFFFFFFF, 0);
    tick(); pc_ctr += 4;
    chk32("x0 bypass rs1_data", rs1_data, 32'h0);
    chk32("addi immediate", immediate, 32'd5);
    cyc(r_type(7'h00, 5'd0, 5'd0, 3'b000, 5'd11), 0);
    chk32("x0 read rs1_data", rs1_data, 32'h0);

    // same-cycle writeback to rs1 = x7
    put(i_type(12'd0, 5'd7, 3'b000, 5'd12, OP_IMM), 0, 1, 0, 0, 1, 5'd7, 32'h1234, 0);
    tick(); pc_ctr += 4;
    chk32("bypass rs1_data", rs1_data, 32'h1234);
    chk32("no-bypass rs1_data", nb_rs1_data, 32'h55);

    // load-use on rs1
    lw8  = i_type(12'd0, 5'd1, 3'b010, 5'd8, OP_LOAD);
    add9 = r_type(7'h00, 5'd2, 5'd8, 3'b000, 5'd9);
    cyc(lw8, 0);
    chk32("lw result_src", {30'b0, result_src_d}, {30'b0, RES_MEM});
    put(add9, 0, 1, 0, 0, 0, 0, 0, 0);
    #1 chk32("lus rs1 asserted", {31'b0, load_use_stall}, 32'h1);
    tick();
    chk32("lus bubble id_valid", {31'b0, id_valid}, 32'h0);
    put(add9, 0, 1, 0, 0, 0, 0, 0, 0);
    #1 chk32("lus released", {31'b0, load_use_stall}, 32'h0);
    tick(); pc_ctr += 4;
    chk32("add after lus id_valid", {31'b0, id_valid}, 32'h1);
    chk32("add after lus rd_out", {27'b0, rd_out}, 32'd9);
    chk32("add after lus rs2_data", rs2_data, 32'h7);

    // load-use on rs2
    cyc(i_type(12'd4, 5'd1, 3'b010, 5'd13, OP_LOAD), 32'd4);
    put(r_type(7'h20, 5'd13, 5'd2, 3'b000, 5'd14), 0, 1, 0, 0, 0, 0, 0, 0);
    #1 chk32("lus rs2 asserted", {31'b0, load_use_stall}, 32'h1);
    tick();
    cyc(r_type(7'h20, 5'd13, 5'd2, 3'b000, 5'd14), 0);
    chk32("sub alu_control", {28'b0, alu_control_d}, {28'b0, ALU_SUB});

    // no hazard for load to x0 or when IF/ID is empty
    cyc(i_type(12'd0, 5'd1, 3'b010, 5'd0, OP_LOAD), 0);
    put(r_type(7'h00, 5'd0, 5'd0, 3'b000, 5'd3), 0, 1, 0, 0, 0, 0, 0, 0);
    #1 chk32("lus rd=x0", {31'b0, load_use_stall}, 32'h0);
    tick();
    cyc(lw8, 0);
    put(add9, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk32("lus if_valid=0", {31'b0, load_use_stall}, 32'h0);
    tick();

    // stall has priority over the hazard, flush over both
    cyc(lw8, 0);
    put(add9, 0, 1, 1, 0, 0, 0, 0, 0); tick();
    chk32("stall holds lw rd", {27'b0, rd_out}, 32'd8);
    put(add9, 0, 1, 0, 0, 0, 0, 0, 0); tick();
    cyc(add9, 0);
    cyc(lw8, 0);
    put(add9, 0, 1, 0, 1, 0, 0, 0, 0); tick();
    chk32("flush during lus", {31'b0, id_valid}, 32'h0);

    // stall for three cycles, register file still written
    cyc(s_type(12'd8, 5'd2, 5'd1), 32'd8);
    for (int k = 0; k < 3; k++) begin
      put(r_type(7'h00, 5'd3, 5'd4, 3'b111, 5'd17), 0, 1, 1, 0, (k == 1), 5'd2, 32'd99, 0);
      tick(); pc_ctr += 4;
      chk32("stall memwrite", {31'b0, memwrite_d}, 32'h1);
      chk32("stall immediate", immediate, 32'd8);
      chk32("stall rs2_data", rs2_data, 32'h7);
    end
    put(add9, 0, 1, 1, 1, 0, 0, 0, 0); tick(); pc_ctr += 4;
    chk32("flush+stall id_valid", {31'b0, id_valid}, 32'h0);
    chk32("flush+stall memwrite", {31'b0, memwrite_d}, 32'h0);
    cyc(r_type(7'h00, 5'd0, 5'd2, 3'b000, 5'd20), 0);
    chk32("write during stall", rs1_data, 32'd99);

    // decode coverage
    cyc({20'h80000, 5'd21, OP_LUI}, 32'h80000000);
    chk32("lui immediate", immediate, 32'h80000000);
    chk32("lui alu_control", {28'b0, alu_control_d}, {28'b0, ALU_PASSB});
    cyc({20'h00001, 5'd22, OP_AUIPC}, 32'h1000);
    cyc(j_type(21'h800, 5'd1), 32'h800);
    chk32("jal immediate", immediate, 32'h800);
    chk32("jal jump", {31'b0, jump_d}, 32'h1);
    cyc(i_type(12'hFFF, 5'd5, 3'b000, 5'd0, OP_JALR), 32'hFFFFFFFF);
    cyc(b_type(13'h1FF8, 5'd2, 5'd1), 32'hFFFFFFF8);
    chk32("beq immediate", immediate, 32'hFFFFFFF8);
    chk32("beq branch", {31'b0, branch_d}, 32'h1);
    cyc(i_type(12'd3, 5'd1, 3'b001, 5'd23, OP_IMM), 32'd3);
    cyc(i_type(12'h404, 5'd1, 3'b101, 5'd24, OP_IMM), 32'h404);
    chk32("srai alu_control", {28'b0, alu_control_d}, {28'b0, ALU_SRA});
    cyc(r_type(7'h20, 5'd2, 5'd1, 3'b101, 5'd25), 0);
    cyc(r_type(7'h00, 5'd2, 5'd1, 3'b110, 5'd26), 0);
    cyc(r_type(7'h00, 5'd2, 5'd1, 3'b111, 5'd27), 0);
    cyc(r_type(7'h00, 5'd2, 5'd1, 3'b010, 5'd28), 0);
    cyc(r_type(7'h00, 5'd2, 5'd1, 3'b011, 5'd29), 0);
    cyc(r_type(7'h00, 5'd2, 5'd1, 3'b100, 5'd30), 0);
    cyc(r_type(7'h00, 5'd2, 5'd1, 3'b101, 5'd31), 0);
    cyc(s_type(12'hFFC, 5'd2, 5'd1), 32'hFFFFFFFC);
    chk32("sw negative immediate", immediate, 32'hFFFFFFFC);
    cyc(32'h002081FF, 0);
    exp_e = '0;
    exp_e.valid = 1'b1;
    chk_ent("undefined opcode", dut_ent, exp_e);

    // reset while a load-use hazard is pending
    cyc(i_type(12'd0, 5'd1, 3'b010, 5'd15, OP_LOAD), 0);
    put(r_type(7'h00, 5'd0, 5'd15, 3'b000, 5'd16), 0, 1, 0, 0, 0, 0, 0, 1);
    #1 chk32("lus before reset", {31'b0, load_use_stall}, 32'h1);
    tick();
    exp_e = '0;
    chk_ent("reset clears id/ex", dut_ent, exp_e);
    #1 chk32("lus after reset", {31'b0, load_use_stall}, 32'h0);
    for (int r = 1; r < 32; r++) begin
      cyc(r_type(7'h00, 5'(r), 5'(r), 3'b000, 5'd3), 0);
      chk32("reset clears regfile", rs1_data | rs2_data, 32'h0);
    end

    put(32'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
